// File: rtl/ibf_config_mc_ram_if.sv
// ibf_config_mc_ram_if: control-plane write port, parser read channels and status of the config table
interface ibf_config_mc_ram_if #(
  parameter int CFG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                         clr;
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [CFG_WIDTH-1:0]         din;
  logic                         wr_ready;
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*CFG_WIDTH-1:0]  config_data;
  logic [NUM_RD-1:0]            data_vld;
  logic                         cfg_ready;
  logic                         addr_err;
  modport master (
    output clr, wr_en, wr_addr, din, rd_en, rd_addr,
    input  wr_ready, config_data, data_vld, cfg_ready, addr_err
  );
  modport slave (
    input  clr, wr_en, wr_addr, din, rd_en, rd_addr,
    output wr_ready, config_data, data_vld, cfg_ready, addr_err
  );
endinterface

// File: rtl/ibf_config_mc_ram.sv
// ibf_config_mc_ram: self-initialising config table with NUM_RD registered read channels and one write port
module ibf_config_mc_ram #(
  parameter int                   CFG_WIDTH  = 32,
  parameter int                   CFG_DEPTH  = 32,
  parameter int                   ADDR_WIDTH = 5,
  parameter int                   NUM_RD     = 2,
  parameter logic [CFG_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic             clk,
  input logic             rst,
  ibf_config_mc_ram_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(CFG_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(CFG_DEPTH - 1);
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [CFG_WIDTH-1:0]  mem [CFG_DEPTH];
  logic [NUM_RD-1:0]     rd_bad;
  logic                  run, wr_go, wr_bad, err;
  assign run    = state == RUN;
  assign wr_go  = run && bus.wr_en && !bus.clr;
  assign wr_bad = wr_go && !in_range(bus.wr_addr);
  assign bus.cfg_ready = run;
  assign bus.wr_ready  = run;
  assign bus.addr_err  = err;
  always_comb begin
    state_nx = bus.clr ? INIT : (!run && cnt == LAST) ? RUN : state;
    cnt_nx   = bus.clr ? '0 : run ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= bus.clr ? 1'b0 : err | wr_bad | (|rd_bad);
    end
  // Entries are defined only by the INIT sweep, never by reset.
  always_ff @(posedge clk)
    if (!run) mem[cnt] <= INIT_VALUE;
    else if (wr_go && !wr_bad) mem[bus.wr_addr] <= bus.din;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic                  s1_vld, vld;
    logic [ADDR_WIDTH-1:0] a, s1_addr;
    logic [CFG_WIDTH-1:0]  dat;
    assign a         = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_bad[i] = run && bus.rd_en[i] && !in_range(a);
    always_ff @(posedge clk) s1_addr <= a;
    // Stage 2 samples the array before this edge's write lands, so reads see writes up to their accept cycle.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s1_vld <= 1'b0;
        vld    <= 1'b0;
        dat    <= '0;
      end else begin
        s1_vld <= run && bus.rd_en[i];
        vld    <= s1_vld;
        if (s1_vld) dat <= in_range(s1_addr) ? mem[s1_addr] : '0;
      end
    assign bus.data_vld[i]                         = vld;
    assign bus.config_data[i*CFG_WIDTH +: CFG_WIDTH] = dat;
  end
endmodule

// File: doc/ibf_config_mc_ram.md
# ibf_config_mc_ram

Multi-port, runtime-writable configuration table for the ibf_pex parser stages. It replaces fixed single-read configuration ROMs with a table that has `NUM_RD` independent registered read channels and one write port. It self-initialises to a fill value after reset or on a soft clear. Parser stages read per-packet configuration from it, and the control plane updates entries while traffic runs.

## Interface
- `CFG_WIDTH`, default 32: width of one configuration entry.
- `CFG_DEPTH`, default 32: number of entries, legal range 2..2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, default 5: width of each address.
- `NUM_RD`, default 2: number of read channels, at least 1.
- `INIT_VALUE`, default 0: `CFG_WIDTH`-bit value written to every entry during initialisation.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clr`  in  1: one-cycle pulse that re-runs initialisation (soft clear).
- `wr_en`  in  1: write request.
- `wr_addr`  in  `ADDR_WIDTH`: write address.
- `din`  in  `CFG_WIDTH`: write data.
- `wr_ready`  out  1: high when writes are accepted.
- `rd_en`  in  `NUM_RD`: per-channel read request.
- `rd_addr`  in  `NUM_RD*ADDR_WIDTH`: channel i address at [i*`ADDR_WIDTH` +: `ADDR_WIDTH`].
- `config_data`  out  `NUM_RD*CFG_WIDTH`: channel i data at [i*`CFG_WIDTH` +: `CFG_WIDTH`].
- `data_vld`  out  `NUM_RD`: per-channel read-data valid.
- `cfg_ready`  out  1: table initialised and serving requests.
- `addr_err`  out  1: sticky out-of-range access flag.

## Operation
- FSM has two states, INIT and RUN. Reset enters INIT with init counter 0.
- INIT:
  - Each cycle, write `INIT_VALUE` to entry[counter], then increment the counter.
  - After writing entry `CFG_DEPTH`-1, move to RUN.
  - `wr_en` and `rd_en` are ignored: no state change and no `data_vld`.
- RUN:
  - A write is accepted when `wr_en` is high. entry[`wr_addr`] is updated at that clock edge.
  - A read on channel i is accepted when `rd_en[i]` is high. All channels are independent and may use the same address.
- `clr` in RUN: move to INIT with counter 0 and clear `addr_err`.
  - A `wr_en` in the same cycle as `clr` is dropped.
  - Reads in the same cycle as `clr` are accepted and complete normally.
- `clr` in INIT: restart the counter at 0.
- Out-of-range access (address >= `CFG_DEPTH`):
  - Write: dropped; `addr_err` set.
  - Read: returns all zeros with `data_vld` asserted; `addr_err` set.
- `addr_err` is cleared only by `rst` or `clr`.
- Read pipeline is two register stages:
  - Stage 1 registers `rd_en` and `rd_addr` per channel.
  - Stage 2 reads the array with the registered address and registers the data and valid.
- Storage is flops or distributed RAM. Read is asynchronous from the stage-1 address; no block-RAM read latency is assumed.

## Timing
- Reset values:
  - `config_data` = 0, `data_vld` = 0, `cfg_ready` = 0, `wr_ready` = 0, `addr_err` = 0.
  - Stage-1 valids = 0.
  - The FSM is in INIT.
- `cfg_ready` and `wr_ready`:
  - Both equal (state == RUN) and are registered.
  - Both rise exactly `CFG_DEPTH` cycles after `rst` deasserts (cycles 0..`CFG_DEPTH`-1 perform the init writes).
  - Both fall the cycle after a `clr`.
- Read latency is 2:
  - A read accepted in cycle t gives `config_data` and `data_vld[i]` = 1 in cycle t+2, for one cycle per request.
  - Back-to-back reads give one result per cycle per channel.
- `config_data` holds its last value while `data_vld` = 0.
- Write/read ordering:
  - A read accepted in cycle t returns data reflecting every write accepted in cycles <= t. This includes a same-address write in cycle t (write-first).
  - A write accepted in cycle t+1 is not visible to that read.
- Clear/read ordering: a read accepted in the `clr` cycle returns pre-clear data, because the first init write commits at the end of t+1.
- `rst` asserted mid-operation:
  - Immediately forces all outputs and stage valids to their reset values. In-flight reads are lost.
  - Initialisation restarts after deassertion.
- Entry contents are not reset asynchronously; only the INIT sweep defines them.

## Test plan
- Reset with `CFG_DEPTH`=32, `INIT_VALUE`=0xA5A5A5A5 -> `cfg_ready` rises 32 cycles after `rst` deasserts; reading addresses 0, 17 and 31 returns 0xA5A5A5A5 two cycles later.
- Write 0x12345678 to address 5, then read address 5 on both channels in the next cycle -> both channels return 0x12345678 with `data_vld`=2'b11 two cycles after the read.
- In the same cycle, write 0xDEADBEEF to address 9 and read address 9 on channel 0 -> the read returns 0xDEADBEEF. A write of 0x1 to address 9 one cycle later does not change that result.
- With `CFG_DEPTH`=20, write address 25 then read address 25 -> `addr_err`=1, the read returns 0 with `data_vld`, and no entry is modified.
- `clr` pulsed together with `wr_en` (address 3, 0x77) and a read of address 3 holding 0x55 -> the read returns 0x55; `cfg_ready` falls; after the INIT sweep address 3 reads `INIT_VALUE`; `addr_err` is cleared.
- `rst` asserted for one cycle mid-INIT and with two reads in flight -> `data_vld` drops to 0 immediately; `cfg_ready` rises `CFG_DEPTH` cycles after deassertion.
